// File: rtl/button_event.sv
// Press-pattern decoder for a debounced button: short, long,
// auto-repeat and double-click events as one-cycle pulses.
`timescale 1ns/1ps
module button_event #(
  parameter int clk_freq      = 95000,
  parameter int long_press_ms = 800,
  parameter int double_gap_ms = 250,
  parameter int repeat_ms     = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic pressed,
  output logic evt_short,
  output logic evt_long,
  output logic evt_repeat,
  output logic evt_double
);

  localparam int MAX_LG = (long_press_ms > double_gap_ms)
                        ? long_press_ms : double_gap_ms;
  localparam int MAX_MS = (MAX_LG > repeat_ms) ? MAX_LG : repeat_ms;
  localparam int MW = $clog2(MAX_MS + 1);
  localparam int PW = (clk_freq > 1) ? $clog2(clk_freq) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(clk_freq - 1);
  localparam logic [MW-1:0] MS_MAX = '1;
  localparam logic [MW-1:0] LONG_LAST = MW'(long_press_ms - 1);
  localparam logic [MW-1:0] GAP_LAST =
    MW'((double_gap_ms > 0) ? double_gap_ms - 1 : 0);
  localparam logic [MW-1:0] REP_LAST =
    MW'((repeat_ms > 0) ? repeat_ms - 1 : 0);
  localparam bit GAP_EN = (double_gap_ms != 0);
  localparam bit REP_EN = (repeat_ms != 0);

  typedef enum logic [2:0] {
    IDLE, PRESS1, HOLD, GAP, WAIT_REL
  } state_t;

  state_t state, state_nx;

  logic lvl, lvl_d;
  logic rise, fall;
  logic [PW-1:0] presc;
  logic [MW-1:0] ms_cnt;
  logic tick, restart;
  logic long_to, gap_to, rep_to;
  logic short_nx, long_nx, rep_nx, dbl_nx;

  assign rise    = lvl & ~lvl_d;
  assign fall    = ~lvl & lvl_d;
  assign pressed = lvl_d;

  // A timeout of N ms fires on the wrap that would make ms_cnt reach N
  assign tick    = (presc == P_LAST);
  assign long_to = tick && (ms_cnt == LONG_LAST);
  assign gap_to  = GAP_EN && tick && (ms_cnt == GAP_LAST);
  assign rep_to  = REP_EN && tick && (ms_cnt == REP_LAST);

  always_comb begin
    state_nx = state;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    rep_nx   = 1'b0;
    dbl_nx   = 1'b0;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nx = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          if (GAP_EN) begin
            state_nx = GAP;
          end else begin
            short_nx = 1'b1;
            state_nx = IDLE;
          end
        end else if (long_to) begin
          long_nx  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          state_nx = IDLE;
        end else if (rep_to) begin
          rep_nx  = 1'b1;
          restart = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          dbl_nx   = 1'b1;
          state_nx = WAIT_REL;
        end else if (gap_to) begin
          short_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_REL: begin
        if (fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) restart = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lvl        <= 1'b0;
      lvl_d      <= 1'b0;
      presc      <= '0;
      ms_cnt     <= '0;
      evt_short  <= 1'b0;
      evt_long   <= 1'b0;
      evt_repeat <= 1'b0;
      evt_double <= 1'b0;
    end else begin
      state      <= state_nx;
      lvl        <= button_in;
      lvl_d      <= lvl;
      evt_short  <= short_nx;
      evt_long   <= long_nx;
      evt_repeat <= rep_nx;
      evt_double <= dbl_nx;
      if (restart) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (tick) begin
        presc <= '0;
        if (ms_cnt != MS_MAX) ms_cnt <= ms_cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule
